// File: rtl/uart_rx_sampler_if.sv
// uart_rx_sampler_if: RX FIFO write side (character, strobes, error flags out; fifo_full_i in)
interface uart_rx_sampler_if #(parameter int MDW = 8) ();
  logic [MDW-1:0] rx_data_o;
  logic rx_valid_o;
  logic parity_err_o;
  logic frame_err_o;
  logic break_o;
  logic overrun_o;
  logic fifo_full_i;
  modport master (output rx_data_o, rx_valid_o, parity_err_o, frame_err_o, break_o, overrun_o, input fifo_full_i);
  modport slave (input rx_data_o, rx_valid_o, parity_err_o, frame_err_o, break_o, overrun_o, output fifo_full_i);
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 16x oversampled UART RX deframer; clk_i/rst_n_i, en_i, rx_i, frame config in, busy_o out, wr = FIFO write port
module uart_rx_sampler #(
  parameter int MDW = 8,
  parameter int PW = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  input  logic rx_i,
  input  logic [PW-1:0] prescale_i,
  input  logic [3:0] data_size_i,
  input  logic [2:0] parity_i,
  input  logic stop2_i,
  output logic busy_o,
  uart_rx_sampler_if.master wr
);
  localparam int IW = (MDW > 1) ? $clog2(MDW) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BRKWAIT} state_t;
  state_t state_q;
  logic [1:0] sync_q;
  logic prev_q;
  logic [PW-1:0] cnt_q;
  logic [3:0] s_q, n_q;
  logic m7_q, m8_q, par_bit_q, par_err_q, fe1_q;
  logic [MDW-1:0] data_q, rx_data_q;
  logic valid_q, perr_q, ferr_q, brk_q, ovr_q;
  logic rxs, tick, t9, t15, maj, par_en, exp_par, is_brk, emit, emit_fe, full;
  logic [3:0] sz;
  assign rxs = sync_q[1];
  assign full = wr.fifo_full_i;
  assign tick = en_i && cnt_q == prescale_i;
  assign t9 = tick && s_q == 4'd9;
  assign t15 = tick && s_q == 4'd15;
  assign maj = (m7_q & m8_q) | (m7_q & rxs) | (m8_q & rxs);
  assign sz = (data_size_i >= 4'd5 && data_size_i <= 4'(MDW)) ? data_size_i : 4'(MDW);
  assign par_en = parity_i inside {3'd1, 3'd2, 3'd4, 3'd5};
  assign exp_par = parity_i == 3'd1 ? ~^data_q : parity_i == 3'd2 ? ^data_q : parity_i == 3'd5;
  assign is_brk = data_q == '0 && !(par_en && par_bit_q) && !maj;
  assign emit = t9 && (state_q == STOP2 || (state_q == STOP1 && (!stop2_i || is_brk)));
  assign emit_fe = !maj || (state_q == STOP2 && fe1_q);
  assign busy_o = state_q != IDLE;
  assign wr.rx_data_o = rx_data_q;
  assign wr.rx_valid_o = valid_q;
  assign wr.parity_err_o = perr_q;
  assign wr.frame_err_o = ferr_q;
  assign wr.break_o = brk_q;
  assign wr.overrun_o = ovr_q;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
      state_q <= IDLE;
      cnt_q <= '0;
      s_q <= '0;
      n_q <= '0;
      m7_q <= 1'b0;
      m8_q <= 1'b0;
      par_bit_q <= 1'b0;
      par_err_q <= 1'b0;
      fe1_q <= 1'b0;
      data_q <= '0;
      rx_data_q <= '0;
      valid_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      brk_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      prev_q <= rxs;
      valid_q <= emit && !full;
      perr_q <= emit && !full && par_err_q;
      ferr_q <= emit && !full && emit_fe;
      brk_q <= emit && state_q == STOP1 && is_brk;
      ovr_q <= emit && full;
      if (emit && !full) rx_data_q <= data_q;
      cnt_q <= (!en_i || tick) ? '0 : cnt_q + 1'b1;
      if (tick) s_q <= s_q + 1'b1;
      if (tick && s_q == 4'd7) m7_q <= rxs;
      if (tick && s_q == 4'd8) m8_q <= rxs;
      if (!en_i) begin
        state_q <= IDLE;
        s_q <= '0;
      end else begin
        case (state_q)
          IDLE: if (prev_q && !rxs) begin
            state_q <= START;
            s_q <= '0;
            cnt_q <= '0;
            n_q <= '0;
            data_q <= '0;
            par_err_q <= 1'b0;
            fe1_q <= 1'b0;
          end
          START: if (t9 && maj) state_q <= IDLE; else if (t15) state_q <= DATA;
          DATA: begin
            if (t9) begin
              data_q[n_q[IW-1:0]] <= maj;
              n_q <= n_q + 1'b1;
            end
            if (t15 && n_q == sz) state_q <= par_en ? PARITY : STOP1;
          end
          PARITY: begin
            if (t9) begin
              par_bit_q <= maj;
              par_err_q <= maj != exp_par;
            end
            if (t15) state_q <= STOP1;
          end
          STOP1: if (t9) begin
            fe1_q <= !maj;
            state_q <= is_brk ? BRKWAIT : stop2_i ? STOP1 : IDLE;
          end else if (t15) state_q <= STOP2;
          STOP2: if (t9) state_q <= IDLE;
          BRKWAIT: if (rxs) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: scoreboard bench for uart_rx_sampler at prescale 2 (48-clock bit period)
module tb_uart_rx_sampler;
  localparam int BP = 48;
  logic clk = 0, rst_n = 0, en = 0, rx = 1, stop2 = 0, busy;
  logic [15:0] prescale = 16'd2;
  logic [3:0] dsz = 4'd8;
  logic [2:0] par = 3'd0;
  int checks = 0, errors = 0;
  logic [12:0] sb[$];
  logic [12:0] act, want;
  logic [7:0] b2b[8] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h3E, 8'hE7};
  uart_rx_sampler_if #(.MDW(8)) wr();
  uart_rx_sampler #(.MDW(8), .PW(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .rx_i(rx), .prescale_i(prescale),
    .data_size_i(dsz), .parity_i(par), .stop2_i(stop2), .busy_o(busy), .wr(wr)
  );
  always #5 clk = ~clk;
  function automatic logic [12:0] ex(input logic v, input logic [7:0] d, input logic pe, input logic fe, input logic bk, input logic ov);
    return {v, d, pe, fe, bk, ov};
  endfunction
  always @(negedge clk) begin
    if (rst_n && (wr.rx_valid_o || wr.break_o || wr.overrun_o)) begin
      act = ex(wr.rx_valid_o, wr.rx_valid_o ? wr.rx_data_o : 8'h00, wr.parity_err_o, wr.frame_err_o, wr.break_o, wr.overrun_o);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe got %h want none", act);
      end else begin
        want = sb.pop_front();
        if (act !== want) begin
          errors++;
          $display("FAIL char got %h want %h (v,data,pe,fe,brk,ovr)", act, want);
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, exp_v);
    end
  endtask
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] d, input logic pflip, input logic s1, input logic s2, input int spike);
    logic [12:0] bits;
    logic [7:0] md;
    int n;
    md = d & 8'((1 << dsz) - 1);
    bits = '0;
    n = 1;
    for (int i = 0; i < int'(dsz); i++) begin
      bits[n] = d[i];
      n++;
    end
    if (par inside {3'd1, 3'd2, 3'd4, 3'd5}) begin
      bits[n] = (par == 3'd1 ? ~^md : par == 3'd2 ? ^md : par == 3'd5) ^ pflip;
      n++;
    end
    bits[n] = s1;
    n++;
    if (stop2) begin
      bits[n] = s2;
      n++;
    end
    for (int i = 0; i < n; i++)
      for (int c = 0; c < BP; c++) begin
        @(negedge clk);
        rx = bits[i] ^ (i == spike && c >= 26 && c < 29);
      end
  endtask
  task automatic idle(input int n);
    @(negedge clk);
    rx = 1'b1;
    wait_clk(n);
  endtask
  initial begin
    wr.fifo_full_i = 1'b0;
    en = 1'b1;
    wait_clk(4);
    chk("rst_valid", wr.rx_valid_o, 0);
    chk("rst_data", wr.rx_data_o, 0);
    chk("rst_flags", {wr.parity_err_o, wr.frame_err_o, wr.break_o, wr.overrun_o}, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    wait_clk(50);
    chk("idle_busy", busy, 0);
    sb.push_back(ex(1, 8'hA5, 0, 0, 0, 0));
    send(8'hA5, 0, 1, 1, -1);
    idle(BP);
    chk("hold_data", wr.rx_data_o, 8'hA5);
    par = 3'd1;
    sb.push_back(ex(1, 8'h03, 0, 0, 0, 0));
    send(8'h03, 0, 1, 1, -1);
    idle(BP);
    par = 3'd5;
    sb.push_back(ex(1, 8'h80, 1, 0, 0, 0));
    send(8'h80, 1, 1, 1, -1);
    idle(BP);
    dsz = 4'd7;
    par = 3'd2;
    stop2 = 1'b1;
    sb.push_back(ex(1, 8'h35, 0, 0, 0, 0));
    send(8'h35, 0, 1, 1, -1);
    idle(BP);
    sb.push_back(ex(1, 8'h35, 1, 0, 0, 0));
    send(8'h35, 1, 1, 1, -1);
    idle(BP);
    sb.push_back(ex(1, 8'h35, 0, 1, 0, 0));
    send(8'h35, 0, 1, 0, -1);
    idle(BP);
    dsz = 4'd8;
    par = 3'd0;
    stop2 = 1'b0;
    @(negedge clk);
    rx = 1'b0;
    wait_clk(20);
    idle(100);
    chk("glitch_busy", busy, 0);
    sb.push_back(ex(1, 8'h5A, 0, 0, 0, 0));
    send(8'h5A, 0, 1, 1, 3);
    idle(BP);
    sb.push_back(ex(1, 8'h00, 0, 1, 1, 0));
    @(negedge clk);
    rx = 1'b0;
    wait_clk(15 * BP);
    idle(2 * BP);
    sb.push_back(ex(1, 8'h11, 0, 0, 0, 0));
    send(8'h11, 0, 1, 1, -1);
    idle(BP);
    wr.fifo_full_i = 1'b1;
    sb.push_back(ex(0, 8'h00, 0, 0, 0, 1));
    send(8'h77, 0, 1, 1, -1);
    idle(BP);
    wr.fifo_full_i = 1'b0;
    sb.push_back(ex(1, 8'h88, 0, 0, 0, 0));
    send(8'h88, 0, 1, 1, -1);
    idle(BP);
    fork
      send(8'h3C, 0, 1, 1, -1);
      begin
        wait_clk(150);
        chk("busy_in_frame", busy, 1);
        en = 1'b0;
        wait_clk(3);
        chk("busy_disabled", busy, 0);
      end
    join
    idle(20);
    chk("busy_still_disabled", busy, 0);
    en = 1'b1;
    idle(BP);
    sb.push_back(ex(1, 8'hC3, 0, 0, 0, 0));
    send(8'hC3, 0, 1, 1, -1);
    idle(BP);
    for (int i = 0; i < 8; i++) sb.push_back(ex(1, b2b[i], 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) send(b2b[i], 0, 1, 1, -1);
    idle(BP);
    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
